// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the reset PC, the bubble instruction and the fetch FSM encoding.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instruction_fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o,
    input  imem_rvalid_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o,
    output imem_rvalid_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs between the memory response and decode.
// Flush wins over push and pop; pointers are single bits so they wrap at two.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         pop_s;

  assign pop_s = pop & (count_r != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_r[0] <= '0;
      entry_r[1] <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        entry_r[wr_ptr_r] <= wr_data;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = entry_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding memory read at a time and
// hands buffered instructions to decode, honouring stall and redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  last_pc_r;
  logic [31:0]  if_pc_s;
  logic [1:0]   count_s;
  fetch_entry_t head_s;
  fetch_entry_t push_entry_s;
  logic         if_valid_s;
  logic         push_s;
  logic         pop_s;
  logic         req_s;

  // Queue handshakes and request issue; a redirect suppresses issue so no stale
  // response can be mistaken for the target's word.
  always_comb begin
    if_valid_s   = (count_s != 2'd0);
    pop_s        = if_valid_s & ~bus.stall_i;
    push_s       = (state_r == WAIT) & bus.imem_rvalid_i & ~bus.redirect_i;
    req_s        = (state_r == IDLE) & (count_s <= 2'd1) & ~bus.redirect_i & ~reset;
    push_entry_s = '{pc: pc_r, instr: bus.imem_rdata_i};
    if (if_valid_s) begin
      if_pc_s = head_s.pc;
    end else begin
      if_pc_s = last_pc_r;
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (bus.redirect_i),
    .wr_data (push_entry_s),
    .count   (count_s),
    .head    (head_s)
  );

  // Fetch FSM and PC register; redirect overrides every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      state_r <= IDLE;
    end else if (bus.redirect_i) begin
      pc_r <= align_word(bus.redirect_pc_i);
      if ((state_r != IDLE) && !bus.imem_rvalid_i) begin
        state_r <= DROP;
      end else begin
        state_r <= IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_i) begin
            pc_r    <= pc_r + 32'd4;
            state_r <= IDLE;
          end
        end
        DROP: begin
          if (bus.imem_rvalid_i) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Remember the last presented PC so the outputs hold it across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_r <= 32'd0;
    end else if (if_valid_s) begin
      last_pc_r <= head_s.pc;
    end
  end

  assign bus.imem_req_o    = req_s;
  assign bus.imem_addr_o   = pc_r;
  assign bus.if_valid_o    = if_valid_s;
  assign bus.if_instr_o    = if_valid_s ? head_s.instr : NOP_INSTR;
  assign bus.if_pc_o       = if_pc_s;
  assign bus.if_pc_plus4_o = if_pc_s + 32'd4;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the decode/control stage.
- Holds the PC and issues single-word reads to instruction memory over a request/response bus with variable latency.
- Buffers returned words in a 2-entry queue and presents one instruction per cycle, with its PC, to decode; decode takes the opcode from if_instr_o[6:0].
- Accepts stall from decode and PC redirects from branch/JAL/JALR resolution.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, word driven on if_instr_o when if_valid_o=0 (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_o  output  1  read request; memory accepts it in the cycle it is high
imem_addr_o  output  32  word address of the request (bits[1:0]=0)
imem_rvalid_i  input  1  response valid; at least 1 cycle after the request
imem_rdata_i  input  32  response instruction word
stall_i  input  1  decode cannot accept this cycle
redirect_i  input  1  control-flow redirect, single-cycle pulse
redirect_pc_i  input  32  redirect target
if_valid_o  output  1  if_instr_o/if_pc_o hold a real instruction
if_instr_o  output  32  instruction word
if_pc_o  output  32  PC of if_instr_o
if_pc_plus4_o  output  32  if_pc_o + 4, used for JAL/JALR link

Behaviour:
- Reset values: PC=RESET_PC; state=IDLE; queue empty; imem_req_o=0; imem_addr_o=RESET_PC; if_valid_o=0; if_instr_o=NOP_INSTR; if_pc_o=0; if_pc_plus4_o=4.
- FSM states: IDLE, WAIT, DROP. At most one request is outstanding.
- IDLE: when queue count + outstanding <= 1, set imem_req_o=1 and imem_addr_o=PC (combinational from the PC register), then go to WAIT. Otherwise stay in IDLE.
- WAIT, on imem_rvalid_i: push {rdata, PC} into the queue, PC<=PC+4, go to IDLE. A new request can issue from IDLE the next cycle.
- WAIT, on redirect_i without rvalid: PC<=target, go to DROP.
- DROP: on imem_rvalid_i, discard the data and go to IDLE. No push occurs.
- Redirect with rvalid in the same cycle: discard the data, PC<=target, go to IDLE.
- Redirect, general rules:
  - Highest priority; it overrides stall_i and any push.
  - The queue is flushed in the same edge, so if_valid_o=0 the next cycle.
  - PC<={redirect_pc_i[31:2],2'b00}; bits[1:0] are forced to zero.
  - In IDLE, the first request to the target issues the cycle after the redirect.
- Queue (2 entries, FIFO order):
  - Head drives if_instr_o, if_pc_o and if_pc_plus4_o; head is popped when if_valid_o & ~stall_i.
  - Push and pop in the same cycle are allowed at any count.
  - Push is guaranteed to find space because of the issue rule above, so there is no overflow path.
- If_* outputs:
  - if_valid_o = queue non-empty.
  - When empty: if_instr_o=NOP_INSTR; if_pc_o and if_pc_plus4_o hold their last values.
  - While stalled, all if_* outputs are stable.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Throughput with 1-cycle memory latency and no stall: one instruction every 2 cycles (req, rvalid).
- Latency: rvalid at edge t gives if_valid_o=1 after edge t when the queue was empty.
- Reset mid-transaction: all state clears immediately. A late rvalid after reset is ignored, because the state is IDLE and rvalid is only consumed in WAIT/DROP.
- rvalid seen in IDLE is ignored.

Decomposition:
- Shared package: RESET_PC, NOP_INSTR, and the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2).
- Sub-module fetch_queue: 2-entry, 64-bit {pc,instr} FIFO.
  - Ports: push, pop, flush, count, head.
  - Pointer wrap at depth 2; flush has priority over push/pop.
- The top level keeps the PC register, the FSM and the output muxing.

Test Plan:
1. Reset release with a 1-cycle-latency memory returning 32'h0000_0033 at every address → first imem_addr_o=32'h0040_0000. if_valid_o=1 with if_pc_o=32'h0040_0000 and if_pc_plus4_o=32'h0040_0004, then 32'h0040_0004 and so on, in order.
2. Hold stall_i=1 for 6 cycles → queue reaches 2 entries, and imem_req_o stays 0 while count=2. After release, if_pc_o sequence is contiguous with no loss and no duplicates.
3. redirect_i with target 32'h0040_0100 while in WAIT with 3-cycle latency → the pending response is dropped, and the next request address is 32'h0040_0100. if_valid_o=0 until that word returns.
4. redirect_i coincident with imem_rvalid_i, target 32'h0040_0203 → data discarded; next imem_addr_o=32'h0040_0200.
5. redirect_i and stall_i together with 2 queued entries → if_valid_o=0 the next cycle; the queue is empty and redirect wins.
6. Assert reset while in WAIT, then deliver rvalid 1 cycle after release → response ignored. The first post-reset request goes to RESET_PC, and if_instr_o=NOP_INSTR until valid.
